// File: rtl/led_pkg.sv
// Shared definitions for the LED/PMOD fader: brightness width, full-scale value
// and the squaring curve applied when GAMMA_EN is defined.
package led_pkg;

    localparam int unsigned LED_BW = 8;

    typedef logic [LED_BW-1:0] bright_t;

    localparam bright_t MAX = '1;

    // Square-law curve: (b*b) >> bw, valid for bw up to 16.
    function automatic logic [31:0] gamma(input logic [15:0] b, input int unsigned bw);
        logic [31:0] sq;
        sq = 32'(b) * 32'(b);
        return sq >> bw;
    endfunction

endpackage

// File: rtl/fade_channel.sv
// One fader channel: brightness register with snap-to-full / linear decay, plus the
// registered PWM compare. GAMMA_EN selects the squared brightness for the compare.
module fade_channel
    import led_pkg::*;
#(
    parameter int unsigned BW         = LED_BW,
    parameter int unsigned DECAY_STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          set,
    input  logic          tick,
    input  logic [BW-1:0] pwm_cnt,
    output logic [BW-1:0] bright,
    output logic          pin
);

    localparam logic [BW-1:0] STEP = BW'(DECAY_STEP);

    logic [BW-1:0] bright_d, bright_q;
    logic [BW-1:0] bright_eff;
    logic          pin_d, pin_q;

    // Set has priority over a coincident decay tick; decay saturates at zero.
    always_comb begin
        bright_d = bright_q;
        if (en) begin
            if (set) begin
                bright_d = '1;
            end else if (tick) begin
                bright_d = (bright_q > STEP) ? bright_q - STEP : '0;
            end
        end
    end

`ifdef GAMMA_EN
    always_comb bright_eff = BW'(gamma(16'(bright_q), BW));
`else
    always_comb bright_eff = bright_q;
`endif

    always_comb pin_d = en & (bright_eff > pwm_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '0;
            pin_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            pin_q    <= pin_d;
        end
    end

    assign bright = bright_q;
    assign pin    = pin_q;

endmodule

// File: rtl/pin_fader.sv
// Fading-trail driver for the sweep pattern: registers the pattern, runs the decay
// prescaler and shared PWM counter, and fans out to per-channel faders. Macro: GAMMA_EN.
module pin_fader
    import led_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned BW         = LED_BW,
    parameter int unsigned DECAY_DIV  = 4096,
    parameter int unsigned DECAY_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] pattern,
    output logic [CHANNELS-1:0] pins,
    output logic                busy
);

    localparam int unsigned   PW       = $clog2(DECAY_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

    logic [CHANNELS-1:0] pat_d, pat_q;
    logic [PW-1:0]       pre_d, pre_q;
    logic [BW-1:0]       pwm_d, pwm_q;
    logic                busy_d, busy_q;
    logic                tick;
    logic [BW-1:0]       bright_w [CHANNELS];

    // Prescaler and PWM counter freeze while disabled so no tick is lost or repeated.
    always_comb begin
        pat_d = pattern;
        pre_d = pre_q;
        pwm_d = pwm_q;
        tick  = 1'b0;
        if (en) begin
            tick  = (pre_q == PRE_LAST);
            pre_d = tick ? '0 : pre_q + 1'b1;
            pwm_d = pwm_q + 1'b1;
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            busy_d = busy_d | (|bright_w[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= '0;
            pre_q  <= '0;
            pwm_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            pre_q  <= pre_d;
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        fade_channel #(
            .BW         (BW),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .set     (pat_q[g]),
            .tick    (tick),
            .pwm_cnt (pwm_q),
            .bright  (bright_w[g]),
            .pin     (pins[g])
        );
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_pin_fader.sv
// Scoreboard bench for pin_fader: the stimulus process queues cycle-stamped
// expectations, a negedge monitor pops them and compares pins, busy and brightness.
module tb_pin_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en2;
    logic [7:0] pattern;
    logic [7:0] pattern2;
    logic [7:0] pins;
    logic [7:0] pins2;
    logic       busy;
    logic       busy2;

    always #5 clk = ~clk;

    pin_fader #(
        .CHANNELS   (8),
        .BW         (8),
        .DECAY_DIV  (4),
        .DECAY_STEP (1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .pattern (pattern),
        .pins    (pins),
        .busy    (busy)
    );

    // Slow, coarse-step instance: holds intermediate brightness levels long enough
    // to measure a full PWM period at a constant level.
    pin_fader #(
        .CHANNELS   (8),
        .BW         (8),
        .DECAY_DIV  (1024),
        .DECAY_STEP (127)
    ) u_duty (
        .clk     (clk),
        .rst     (rst),
        .en      (en2),
        .pattern (pattern2),
        .pins    (pins2),
        .busy    (busy2)
    );

    logic [7:0] b0, b3;
    assign b0 = u_dut.bright_w[0];
    assign b3 = u_dut.bright_w[3];

`ifdef GAMMA_EN
    localparam int FULL_EFF   = 254;
    localparam int HALF_EFF   = 64;
    localparam int ONE_EFF    = 0;
    localparam int RESUME_PIN = 9'h100;
`else
    localparam int FULL_EFF   = 255;
    localparam int HALF_EFF   = 128;
    localparam int ONE_EFF    = 1;
    localparam int RESUME_PIN = 9'h108;
`endif

    localparam int K_SNAP   = 0;
    localparam int K_BRIGHT = 1;
    localparam int K_WIN    = 2;
    localparam int NW       = 8;

    typedef struct {
        int    at;
        int    kind;
        int    sel;
        int    arg;
        int    len;
        int    exp;
        string name;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    bit    w_on   [NW];
    int    w_sel  [NW];
    int    w_mask [NW];
    int    w_left [NW];
    int    w_cnt  [NW];
    int    w_exp  [NW];
    string w_name [NW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int at, input int kind, input int sel, input int arg,
                        input int len, input int exp, input string name);
        exp_t e;
        e.at = at; e.kind = kind; e.sel = sel; e.arg = arg;
        e.len = len; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic snap(input int at, input int exp, input string name);
        push(at, K_SNAP, 0, 0, 0, exp, name);
    endtask

    task automatic bright(input int at, input int ch, input int exp, input string name);
        push(at, K_BRIGHT, 0, ch, 0, exp, name);
    endtask

    task automatic window(input int at, input int sel, input int mask, input int len,
                          input int exp, input string name);
        push(at, K_WIN, sel, mask, len, exp, name);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: expectations fire on the negedge after their stamped posedge.
    exp_t m_e;
    bit   m_placed;
    int   m_smp;
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                m_e = sb[i];
                sb.delete(i);
                if (m_e.at < cyc) begin
                    check({m_e.name, "_late"}, m_e.at, cyc);
                end else if (m_e.kind == K_SNAP) begin
                    check(m_e.name, int'({busy, pins}), m_e.exp);
                end else if (m_e.kind == K_BRIGHT) begin
                    check(m_e.name, (m_e.arg == 0) ? int'(b0) : int'(b3), m_e.exp);
                end else begin
                    m_placed = 1'b0;
                    for (int s = 0; s < NW; s++) begin
                        if (!m_placed && !w_on[s]) begin
                            w_on[s]   = 1'b1;
                            w_sel[s]  = m_e.sel;
                            w_mask[s] = m_e.arg;
                            w_left[s] = m_e.len;
                            w_cnt[s]  = 0;
                            w_exp[s]  = m_e.exp;
                            w_name[s] = m_e.name;
                            m_placed  = 1'b1;
                        end
                    end
                    if (!m_placed) check({m_e.name, "_noslot"}, 0, 1);
                end
            end
        end
        for (int s = 0; s < NW; s++) begin
            if (w_on[s]) begin
                m_smp = (w_sel[s] != 0) ? int'(pins2) : int'(pins);
                if ((m_smp & w_mask[s]) != 0) w_cnt[s]++;
                w_left[s]--;
                if (w_left[s] == 0) begin
                    check(w_name[s], w_cnt[s], w_exp[s]);
                    w_on[s] = 1'b0;
                end
            end
        end
    end

    initial begin
        int r;
        int s;
        int active;
        rst = 1'b1; en = 1'b1; en2 = 1'b1;
        pattern = 8'hFF; pattern2 = 8'h00;

        // Reset with the pattern already high, then release.
        snap(1, 0, "rst_hold1");
        snap(2, 0, "rst_hold2");
        wait_to(2);
        rst = 1'b0;
        snap(3, 0, "rel_e1");
        snap(4, 0, "rel_e2");
        snap(5, 9'h1FF, "rel_e3_rise");
        window(6, 0, 8'h01, 256, FULL_EFF, "full_duty_pin0");

        // Reset from full brightness clears everything.
        wait_to(270);
        rst = 1'b1; pattern = 8'h00;
        snap(271, 0, "rst_mid_e1");
        snap(272, 0, "rst_mid_e2");
        bright(271, 0, 0, "rst_bright0");

        // Set/release of channel 0, slow-instance duty levels.
        wait_to(272);
        r = 272;
        rst = 1'b0; pattern = 8'h01; pattern2 = 8'h01;
        snap(r + 1, 0, "set_e1");
        bright(r + 4, 0, 255, "set_full");
        snap(r + 5, 9'h101, "set_pin0");
        bright(r + 7, 0, 255, "pre_tick");
        bright(r + 8, 0, 254, "first_decay");
        bright(r + 12, 0, 253, "second_decay");
        bright(r + 1023, 0, 1, "decay_last1");
        bright(r + 1024, 0, 0, "decay_zero");
        snap(r + 1024, 9'h100, "busy_lag");
        snap(r + 1025, 0, "busy_fall");
        window(r + 1, 0, 8'hFE, 1025, 0, "others_quiet");
        window(r + 1100, 1, 8'h01, 256, HALF_EFF, "duty_half");
        window(r + 2100, 1, 8'h01, 256, ONE_EFF, "duty_one");
        wait_to(r + 3);
        pattern = 8'h00; pattern2 = 8'h00;

        // Channel 3 decays to 10, then is re-set on a tick cycle.
        s = r + 1032;
        wait_to(s);
        pattern = 8'h08;
        bright(s + 2, 3, 255, "ch3_set");
        bright(s + 4, 3, 254, "ch3_decay");
        bright(s + 980, 3, 10, "ch3_at10");
        bright(s + 983, 3, 10, "ch3_hold10");
        bright(s + 984, 3, 255, "collision_set_wins");
        bright(s + 988, 3, 254, "post_collision");
        wait_to(s + 1);
        pattern = 8'h00;
        wait_to(s + 982);
        pattern = 8'h08;
        wait_to(s + 983);
        pattern = 8'h00;

        // Freeze at brightness 100 for 50 cycles, one prescaler count in.
        bright(s + 1603, 3, 101, "ch3_at101");
        bright(s + 1604, 3, 100, "ch3_at100");
        snap(s + 1606, 9'h100, "freeze_blank");
        window(s + 1606, 0, 8'hFF, 50, 0, "freeze_dark");
        bright(s + 1630, 3, 100, "freeze_mid");
        bright(s + 1655, 3, 100, "freeze_end");
        snap(s + 1656, RESUME_PIN, "resume_pwm_held");
        bright(s + 1657, 3, 100, "resume_no_tick");
        bright(s + 1658, 3, 99, "resume_tick");
        wait_to(s + 1605);
        en = 1'b0;
        wait_to(s + 1655);
        en = 1'b1;

        wait_to(s + 1700);
        active = 0;
        for (int i = 0; i < NW; i++) if (w_on[i]) active++;
        check("drained", sb.size() + active, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
